lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store sequencer between the pipeline MEM stage and the byte-addressed, big-endian data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Checks alignment, then drives the memory's address, mode, bidirectional data bus and write/read strobes with defined setup and hold cycles.
- For loads, waits for the memory's read-status flag, captures the word, applies sign or zero extension, and returns a single-cycle response.

Parameters:
- WIDTH, 32, data/address width.
- RD_TIMEOUT, 8, maximum cycles in RD_WAIT before a load is aborted with an error.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 word, 1 halfword, 2 byte, 3 illegal.
- req_signed  in  1  load sign-extends when 1; ignored for stores.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size, or read timeout; qualified by resp_valid.
- mem_add  out  WIDTH  memory byte address.
- mem_data  inout  WIDTH  memory data bus.
- mem_wr  out  1  write strobe; memory acts on its rising edge.
- mem_rd  out  1  read strobe; memory acts on its rising edge.
- mem_mode  out  2  0 word, 1 halfword, 2 byte.
- mem_rd_st  in  1  memory read-complete flag.

Behaviour:
- Reset values (rst=1 at a clk edge, any state):
  - state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_wr=0, mem_rd=0, mem_add=0, mem_mode=0; mem_data released (high-Z).
  - Any in-flight request is dropped with no response. A strobe high at reset falls on that edge.
- Handshake:
  - req_ready=1 only in IDLE.
  - Accept on req_valid & req_ready: latch we/size/signed/addr/wdata. req_ready drops on the next cycle.
- Error check at accept; an error skips all memory activity:
  - size=3 is an error.
  - word with addr[1:0]!=0 is an error.
  - half with addr[0]!=0 is an error.
  - Error path goes to ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE.
- Store path (accept at cycle T):
  - WSETUP (T+1): mem_add/mem_mode valid, mem_data driven with latched wdata, mem_wr=0.
  - WSTROBE (T+2): mem_wr=1.
  - WHOLD (T+3): mem_wr=0, address/mode/data still driven.
  - RESP (T+4): resp_valid=1, resp_err=0, resp_rdata=0; mem_data released.
  - Total latency 4 cycles accept-to-resp.
- Load path:
  - RSETUP: address/mode valid, mem_rd=0, bus released.
  - RSTROBE: mem_rd=1.
  - RD_WAIT: mem_rd held 1; counter starts at 0.
    - First cycle with mem_rd_st=1: capture mem_data, go to RESP.
    - Otherwise increment the counter. When the counter reaches RD_TIMEOUT, go to ERR with resp_err=1.
  - mem_rd returns to 0 on leaving RD_WAIT.
  - Minimum load latency: 4 cycles (accept T, RSETUP T+1, RSTROBE T+2, RD_WAIT T+3 with rd_st=1, RESP T+4).
- Bus ownership: mem_data is driven only in WSETUP, WSTROBE and WHOLD. It is high-Z in every other state, including reset.
- Load extension, from the captured word (memory returns halfword/byte data right-justified):
  - word: unchanged.
  - half: low 16 bits; upper bits = bit15 if signed, else 0.
  - byte: low 8 bits; upper bits = bit7 if signed, else 0.
- Stores pass wdata unmodified; the memory selects the low bytes per mode.
- resp_valid is a single-cycle pulse regardless of downstream; there is no response backpressure.
- req_valid during a busy state is ignored (not queued).
- Back-to-back requests: IDLE is re-entered the cycle after RESP/ERR, so the earliest next accept is RESP+1.
- rst asserted in the same cycle as req_valid: reset wins; request not accepted.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word signed @0x10 -> mem_wr high exactly at T+2, resp_valid at T+4; load returns resp_rdata=0xDEADBEEF, resp_err=0.
- Store byte 0x80 @0x13, then load byte signed / unsigned @0x13 -> 0xFFFFFF80 / 0x00000080.
- Load halfword @0x11 and word @0x12 -> no mem_rd or mem_wr pulse; resp_valid with resp_err=1 on the cycle after accept; req_size=3 behaves the same.
- Load with mem_rd_st forced 0 -> mem_rd stays high for RD_TIMEOUT=8 cycles in RD_WAIT, then resp_err=1, mem_rd=0, back in IDLE.
- Assert rst during WSTROBE -> next edge: mem_wr=0, mem_data high-Z, req_ready=1, no resp_valid ever issued for that request.
- Hold req_valid high across a store -> second request accepted only the cycle after RESP; exactly one resp_valid per accept.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Request/response and memory-control bundle for the LSU MEM-stage sequencer.
// The tristate data bus stays a plain inout port on the sequencer itself.
interface lsu_mem_stage_if #(
   parameter int WIDTH = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [WIDTH-1:0]  req_addr;
   logic [WIDTH-1:0]  req_wdata;
   logic              resp_valid;
   logic [WIDTH-1:0]  resp_rdata;
   logic              resp_err;
   logic [WIDTH-1:0]  mem_add;
   logic              mem_wr;
   logic              mem_rd;
   logic [1:0]        mem_mode;
   logic              mem_rd_st;

   // master: the pipeline and memory around the sequencer; slave: the sequencer
   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd_st,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_add, mem_wr, mem_rd, mem_mode
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd_st,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_add, mem_wr, mem_rd, mem_mode
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store sequencer: one request at a time, strobed access to a big-endian
// byte memory with setup/hold cycles, load extension and a read timeout.
module lsu_mem_stage #(
   parameter int WIDTH      = 32,
   parameter int RD_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   lsu_mem_stage_if.slave   bus,
   inout  wire  [WIDTH-1:0] mem_data
);
   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ERR, S_WSETUP, S_WSTROBE, S_WHOLD,
      S_RSETUP, S_RSTROBE, S_RD_WAIT, S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [WIDTH-1:0]  r_addr;
   logic [WIDTH-1:0]  r_wdata;
   logic [WIDTH-1:0]  r_rdata_p1;
   logic              w_accept;
   logic              w_bad;
   logic              w_drive;
   logic              w_mem_act;

   function automatic logic [WIDTH-1:0] f_extend(input logic [WIDTH-1:0] word,
                                                 input logic [1:0]       size,
                                                 input logic             sgn);
      case (size)
         2'd1:    f_extend = {{(WIDTH-16){sgn & word[15]}}, word[15:0]};
         2'd2:    f_extend = {{(WIDTH-8){sgn & word[7]}}, word[7:0]};
         default: f_extend = word;
      endcase
   endfunction

   assign w_accept = bus.req_valid && (r_state == S_IDLE);
   assign w_bad    = (bus.req_size == 2'd3) ||
                     ((bus.req_size == 2'd0) && (bus.req_addr[1:0] != 2'b00)) ||
                     ((bus.req_size == 2'd1) && bus.req_addr[0]);

   // Request fields and read capture carry no reset; the state machine qualifies them
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we     <= bus.req_we;
         r_size   <= bus.req_size;
         r_signed <= bus.req_signed;
         r_addr   <= bus.req_addr;
         r_wdata  <= bus.req_wdata;
      end
      if ((r_state == S_RD_WAIT) && bus.mem_rd_st)
         r_rdata_p1 <= mem_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_RD_WAIT) ? r_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bus.req_valid) w_next = w_bad ? S_ERR : (bus.req_we ? S_WSETUP : S_RSETUP);
         S_WSETUP:  w_next = S_WSTROBE;
         S_WSTROBE: w_next = S_WHOLD;
         S_WHOLD:   w_next = S_RESP;
         S_RSETUP:  w_next = S_RSTROBE;
         S_RSTROBE: w_next = S_RD_WAIT;
         S_RD_WAIT: begin
            if (bus.mem_rd_st)          w_next = S_RESP;
            else if (r_cnt == CNT_LAST) w_next = S_ERR;
         end
         S_RESP:    w_next = S_IDLE;
         S_ERR:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_drive = (r_state == S_WSETUP) || (r_state == S_WSTROBE) || (r_state == S_WHOLD);
      w_mem_act = w_drive || (r_state == S_RSETUP) || (r_state == S_RSTROBE) ||
                  (r_state == S_RD_WAIT);
      bus.req_ready  = (r_state == S_IDLE);
      bus.resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
      bus.resp_err   = (r_state == S_ERR);
      bus.resp_rdata = ((r_state == S_RESP) && !r_we) ? f_extend(r_rdata_p1, r_size, r_signed)
                                                      : '0;
      bus.mem_wr     = (r_state == S_WSTROBE);
      bus.mem_rd     = (r_state == S_RSTROBE) || (r_state == S_RD_WAIT);
      bus.mem_add    = w_mem_act ? r_addr : '0;
      bus.mem_mode   = w_mem_act ? r_size : 2'd0;
   end

   assign mem_data = w_drive ? r_wdata : {WIDTH{1'bz}};
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a big-endian byte memory model.
module tb_lsu_mem_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_st_en = 1'b1;
   logic [31:0] rd_val;
   logic [7:0]  mem [0:255] = '{default: 8'h00};
   wire  [31:0] mem_data;
   int          checks = 0;
   int          failures = 0;

   lsu_mem_stage_if #(.WIDTH(32)) bus ();

   lsu_mem_stage #(.WIDTH(32), .RD_TIMEOUT(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mem_data (mem_data)
   );

   always #5 clk = ~clk;

   // Memory model: read data right-justified, read-complete as soon as mem_rd is high
   always_comb begin
      int a;
      a = int'(bus.mem_add[7:0]);
      case (bus.mem_mode)
         2'd0:    rd_val = {mem[a], mem[(a+1)%256], mem[(a+2)%256], mem[(a+3)%256]};
         2'd1:    rd_val = {16'h0, mem[a], mem[(a+1)%256]};
         default: rd_val = {24'h0, mem[a]};
      endcase
   end
   assign mem_data      = bus.mem_rd ? rd_val : 32'hzzzz_zzzz;
   assign bus.mem_rd_st = bus.mem_rd & rd_st_en;

   always @(posedge bus.mem_wr) begin
      int a;
      a = int'(bus.mem_add[7:0]);
      case (bus.mem_mode)
         2'd0: begin
            mem[a] = mem_data[31:24]; mem[(a+1)%256] = mem_data[23:16];
            mem[(a+2)%256] = mem_data[15:8]; mem[(a+3)%256] = mem_data[7:0];
         end
         2'd1: begin
            mem[a] = mem_data[15:8]; mem[(a+1)%256] = mem_data[7:0];
         end
         default: mem[a] = mem_data[7:0];
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE and watch it until its response (bounded)
   task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wr_cyc, output int wr_cnt, output int rd_cnt,
                          output logic [31:0] add1, output logic [1:0] mode1,
                          output logic [31:0] data1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      tick();
      bus.req_valid = 1'b0;
      lat = -1; wr_cyc = -1; wr_cnt = 0; rd_cnt = 0;
      rdata = 32'hx; err = 1'bx;
      add1 = bus.mem_add; mode1 = bus.mem_mode; data1 = mem_data;
      for (int c = 1; c <= 20; c++) begin
         if (bus.mem_wr) begin
            wr_cnt++;
            if (wr_cyc < 0) wr_cyc = c;
         end
         if (bus.mem_rd) rd_cnt++;
         if (bus.resp_valid) begin
            lat = c; rdata = bus.resp_rdata; err = bus.resp_err;
            break;
         end
         tick();
      end
      tick();
      chk("resp_single_pulse", {31'b0, bus.resp_valid}, 32'd0);
   endtask

   int          lat, wr_cyc, wr_cnt, rd_cnt, n_resp, n_acc, first_resp, second_acc;
   logic [31:0] rdata, add1, data1;
   logic [1:0]  mode1;
   logic        err;

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
      bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      tick(); tick();
      chk("rst_ready",   {31'b0, bus.req_ready},  32'd1);
      chk("rst_resp_v",  {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_rdata",   bus.resp_rdata,          32'd0);
      chk("rst_err",     {31'b0, bus.resp_err},   32'd0);
      chk("rst_strobes", {30'b0, bus.mem_wr, bus.mem_rd}, 32'd0);
      chk("rst_add",     bus.mem_add,             32'd0);
      chk("rst_mode",    {30'b0, bus.mem_mode},   32'd0);
      rst = 1'b0;
      tick();

      run_req(1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("stw_lat",    lat,    32'd4);
      chk("stw_wr_cyc", wr_cyc, 32'd2);
      chk("stw_wr_cnt", wr_cnt, 32'd1);
      chk("stw_rd_cnt", rd_cnt, 32'd0);
      chk("stw_err",    {31'b0, err}, 32'd0);
      chk("stw_rdata",  rdata,  32'd0);
      chk("stw_add",    add1,   32'h10);
      chk("stw_data",   data1,  32'hDEADBEEF);

      run_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ldw_lat",    lat,    32'd4);
      chk("ldw_rdata",  rdata,  32'hDEADBEEF);
      chk("ldw_err",    {31'b0, err}, 32'd0);
      chk("ldw_rd_cnt", rd_cnt, 32'd2);
      chk("ldw_wr_cnt", wr_cnt, 32'd0);

      run_req(1'b1, 2'd2, 1'b0, 32'h13, 32'h12345680, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("stb_lat",  lat, 32'd4);
      chk("stb_mode", {30'b0, mode1}, 32'd2);
      chk("stb_data", data1, 32'h12345680);

      run_req(1'b0, 2'd2, 1'b1, 32'h13, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ldb_s", rdata, 32'hFFFFFF80);
      run_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ldb_u", rdata, 32'h00000080);
      run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ldh_s", rdata, 32'hFFFFDEAD);
      run_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ldh_u", rdata, 32'h0000DEAD);
      run_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ldw_after_stb", rdata, 32'hDEADBE80);

      // Alignment/size errors: response on the cycle after accept, no strobes
      run_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("eh_lat", lat, 32'd1);
      chk("eh_err", {31'b0, err}, 32'd1);
      chk("eh_strobes", wr_cnt + rd_cnt, 32'd0);
      run_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("ew_lat", lat, 32'd1);
      chk("ew_err", {31'b0, err}, 32'd1);
      chk("ew_rdata", rdata, 32'd0);
      chk("ew_strobes", wr_cnt + rd_cnt, 32'd0);
      run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("es_lat", lat, 32'd1);
      chk("es_err", {31'b0, err}, 32'd1);
      chk("es_strobes", wr_cnt + rd_cnt, 32'd0);
      run_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h55555555, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("esw_err", {31'b0, err}, 32'd1);
      chk("esw_wr_cnt", wr_cnt, 32'd0);

      // Read timeout: RSETUP, RSTROBE, 8 cycles of RD_WAIT, then ERR
      rd_st_en = 1'b0;
      run_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("to_lat", lat, 32'd11);
      chk("to_err", {31'b0, err}, 32'd1);
      chk("to_rdata", rdata, 32'd0);
      chk("to_rd_cnt", rd_cnt, 32'd9);
      chk("to_ready", {31'b0, bus.req_ready}, 32'd1);
      rd_st_en = 1'b1;

      // Reset during WSTROBE drops the store without a response
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
      bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D;
      tick();
      bus.req_valid = 1'b0;
      tick();
      chk("rw_wstrobe", {31'b0, bus.mem_wr}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_wr", {31'b0, bus.mem_wr}, 32'd0);
      chk("rw_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rw_add", bus.mem_add, 32'd0);
      n_resp = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.resp_valid) n_resp++;
         tick();
      end
      chk("rw_no_resp", n_resp, 32'd0);

      // Reset together with req_valid: request is not accepted
      rst = 1'b1; bus.req_valid = 1'b1;
      tick();
      rst = 1'b0; bus.req_valid = 1'b0;
      chk("rv_ready", {31'b0, bus.req_ready}, 32'd1);
      n_resp = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.resp_valid || bus.mem_wr) n_resp++;
         tick();
      end
      chk("rv_idle", n_resp, 32'd0);

      // req_valid held high: re-accept only the cycle after RESP
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h11223344;
      n_resp = 0; n_acc = 0; first_resp = -1; second_acc = -1;
      for (int c = 0; c < 10; c++) begin
         if (bus.req_ready) begin
            n_acc++;
            if (n_acc == 2) second_acc = c;
         end
         if (bus.resp_valid) begin
            n_resp++;
            if (first_resp < 0) first_resp = c;
         end
         tick();
      end
      bus.req_valid = 1'b0;
      chk("hv_acc", n_acc, 32'd2);
      chk("hv_resp", n_resp, 32'd2);
      chk("hv_first_resp", first_resp, 32'd4);
      chk("hv_second_acc", second_acc, 32'd5);
      tick();
      run_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, lat, rdata, err, wr_cyc, wr_cnt, rd_cnt, add1, mode1, data1);
      chk("hv_readback", rdata, 32'h11223344);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
